// File: rtl/spi_rom_ctrl.sv
// spi_rom_ctrl: serial-flash boot-ROM reader for Zorro slave ROM cycles.
// Issues READ_CMD plus a 24-bit address on an SPI mode-0 bus, shifts in 1 or
// 4 data bytes and returns them big-endian on rdata with a one-cycle done.
// Optional feature: define SPI_ROM_SEQ_EN to park with CS low after a read
// and continue a sequential read without resending command and address.

module spi_rom_ctrl #(
    parameter int unsigned CLK_DIV     = 1,      // SPI half-period in CLK cycles (1..15)
    parameter logic [7:0]  READ_CMD    = 8'h03,
    parameter int unsigned CS_HIGH_CYC = 2       // min CS-high cycles between reads (1..15)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        long,
    input  logic [23:0] addr,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        SPI_CLK,
    output logic        SPI_MOSI,
    output logic        SPI_CS_n,
    input  logic        SPI_MISO
);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, GAP
`ifdef SPI_ROM_SEQ_EN
        , PARK
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  div_cnt;     // CLK cycles within the current SPI half-period
    logic [6:0]  bit_cnt;     // SPI clock periods still to run
    logic [3:0]  gap_cnt;     // CLK cycles spent in GAP
    logic [31:0] tx;          // {command, address}, shifted out MSB first
    logic [31:0] rx;          // received data, shifted in MSB first
    logic        long_q;      // 4-byte read in progress

    // Decoded strobes shared by the next-state logic and the datapath
    logic       accept, tick, rise, fall, shift_end, kill, finish, gap_end;
    logic [6:0] data_bits;

`ifdef SPI_ROM_SEQ_EN
    logic [23:0] next_addr;   // address that would continue the parked read
    logic [7:0]  park_cnt;    // idle cycles spent parked
    logic        resume, park_exit;
`endif

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: state_nxt = abort ? GAP : SHIFT;
            SHIFT: begin
                if (abort)          state_nxt = GAP;
                else if (shift_end) state_nxt = HOLD;
            end
`ifdef SPI_ROM_SEQ_EN
            HOLD:  state_nxt = abort ? GAP : PARK;
            // A continuation re-enters through SETUP so its latency keeps the
            // same two-cycle overhead as a full read.
            PARK: begin
                if (resume)         state_nxt = SETUP;
                else if (park_exit) state_nxt = GAP;
            end
`else
            HOLD:  state_nxt = GAP;
`endif
            GAP:   if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/strobe decode: SPI clock divider ticks, accept, abort and exit conditions
    always_comb begin
        data_bits = long_q ? 7'd32 : 7'd8;
        tick      = (state == SHIFT) && (div_cnt == 4'(CLK_DIV - 1));
        rise      = tick && !SPI_CLK;
        fall      = tick && SPI_CLK;
        shift_end = fall && (bit_cnt == 7'd0);
        accept    = (state == IDLE) && req && !abort;
        kill      = abort && ((state == SETUP) || (state == SHIFT) || (state == HOLD));
        finish    = (state == HOLD) && !abort;
        gap_end   = (state == GAP) && (gap_cnt == 4'(CS_HIGH_CYC - 1));
`ifdef SPI_ROM_SEQ_EN
        resume    = (state == PARK) && req && !abort && (addr == next_addr);
        park_exit = (state == PARK) &&
                    (abort || (req && (addr != next_addr)) || (park_cnt == 8'd254));
`endif
    end

    // Datapath: shift registers, counters and registered SPI/handshake outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            long_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            SPI_CLK  <= 1'b0;
            SPI_MOSI <= 1'b0;
            SPI_CS_n <= 1'b1;
`ifdef SPI_ROM_SEQ_EN
            next_addr <= '0;
            park_cnt  <= '0;
`endif
        end else begin
            done    <= 1'b0;
            div_cnt <= (state == SHIFT && !tick) ? div_cnt + 4'd1 : 4'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;

            if (accept) begin
                long_q   <= long;
                tx       <= {READ_CMD, addr};
                bit_cnt  <= long ? 7'd64 : 7'd40;
                SPI_CS_n <= 1'b0;
                busy     <= 1'b1;
            end

            if (state == SETUP) SPI_MOSI <= tx[31];

            // Rising SPI edge: sample MISO; only the trailing data bits enter rx
            if (rise) begin
                SPI_CLK <= 1'b1;
                bit_cnt <= bit_cnt - 7'd1;
                if (bit_cnt <= data_bits) rx <= {rx[30:0], SPI_MISO};
            end

            // Falling SPI edge: present the next bit; zeros follow the address
            if (fall) begin
                SPI_CLK  <= 1'b0;
                tx       <= {tx[30:0], 1'b0};
                SPI_MOSI <= tx[30];
            end

            if (finish) begin
                done  <= 1'b1;
                rdata <= long_q ? rx : {rx[7:0], 24'h0};
`ifdef SPI_ROM_SEQ_EN
                busy  <= 1'b0;
`else
                SPI_CS_n <= 1'b1;
`endif
            end

            // NOTE: with non-blocking assignments the last one in the block wins,
            // so the abort path placed here overrides any clock edge above.
            if (kill) begin
                SPI_CS_n <= 1'b1;
                SPI_CLK  <= 1'b0;
                SPI_MOSI <= 1'b0;
            end

            if (gap_end) busy <= 1'b0;

`ifdef SPI_ROM_SEQ_EN
            park_cnt <= (state == PARK) ? park_cnt + 8'd1 : 8'd0;
            if (accept || resume) next_addr <= addr + (long ? 24'd4 : 24'd1);
            if (resume) begin
                long_q  <= long;
                tx      <= '0;
                bit_cnt <= long ? 7'd32 : 7'd8;
                busy    <= 1'b1;
            end
            if (park_exit) SPI_CS_n <= 1'b1;
`endif
        end
    end

endmodule
